// File: rtl/odometer_meas_seq.sv
// Odometer measurement sequencer: triggers measurements, waits for the
// stress phase to finish, and queues BF_COUNT results in a small FIFO.
// Optional watchdog on the wait states: define ODO_SEQ_TIMEOUT_EN.
module odometer_meas_seq #(
    parameter int INTERVAL_W     = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TRIG_CYCLES    = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic [INTERVAL_W-1:0] INTERVAL,
    input  logic [7:0]            NUM_MEAS,
    input  logic                  MEAS_STRESS,
    input  logic [11:0]           BF_COUNT,
    output logic                  MEAS_TRIG,
    output logic                  BUSY,
    output logic [11:0]           RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic                  FIFO_FULL,
    output logic                  OVERFLOW,
    output logic [7:0]            MEAS_CNT,
    output logic                  TIMEOUT_ERR
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PMAX = (TRIG_CYCLES > SETTLE_CYCLES) ?
                          TRIG_CYCLES : SETTLE_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [PW-1:0] TRIG_LAST   = PW'(TRIG_CYCLES - 1);
    // A zero settle time still spends one cycle in SETTLE.
    localparam logic [PW-1:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? PW'(SETTLE_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INTERVAL,
        TRIG,
        WAIT_START,
        WAIT_DONE,
        SETTLE,
        CAPTURE
    } state_t;

    state_t state;
    state_t state_next;

    logic                  ms_meta;
    logic                  ms_s;
    logic                  ms_prev;
    logic [INTERVAL_W-1:0] icnt;
    logic [PW-1:0]         pcnt;
    logic                  meas_trig;
    logic [7:0]            meas_cnt;
    logic                  overflow;
    logic                  last_meas;
    logic                  entering;
    logic                  in_wait;
    logic                  wd_hit;
    logic                  to_flag;
    logic                  timeout_err;

    logic [11:0]           mem [FIFO_DEPTH];
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  cap;
    logic                  push;
    logic [11:0]           push_data;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
    assign pop        = !fifo_empty && RD_READY;
    assign cap        = (state == CAPTURE);
    // A pop in the capture cycle frees the slot the push needs.
    assign push       = cap && (!fifo_full || pop);
    assign push_data  = to_flag ? 12'hFFF : BF_COUNT;

    assign entering  = (state_next != state);
    assign in_wait   = (state == WAIT_START) || (state == WAIT_DONE);
    assign last_meas = (NUM_MEAS != 8'd0) &&
                       (({1'b0, meas_cnt} + 9'd1) == {1'b0, NUM_MEAS});

    assign MEAS_TRIG   = meas_trig;
    assign BUSY        = (state != IDLE);
    assign RD_VALID    = !fifo_empty;
    assign RD_DATA     = fifo_empty ? 12'h000 : mem[rptr[AW-1:0]];
    assign FIFO_FULL   = fifo_full;
    assign OVERFLOW    = overflow;
    assign MEAS_CNT    = meas_cnt;
    assign TIMEOUT_ERR = timeout_err;

`ifdef ODO_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wcnt;

    assign wd_hit = in_wait && (wcnt == WD_LAST);

    // Watchdog: restarts on entry to each wait state, flags expiry.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wcnt        <= '0;
            to_flag     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (entering) begin
                wcnt <= '0;
            end else if (in_wait) begin
                wcnt <= wcnt + WW'(1);
            end
            if (in_wait && state_next == CAPTURE) begin
                to_flag     <= 1'b1;
                timeout_err <= 1'b1;
            end else if (cap) begin
                to_flag <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
    assign wd_hit      = 1'b0;
    assign to_flag     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Two-flop synchronizer plus history for MEAS_STRESS edge detection.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ms_meta <= 1'b0;
            ms_s    <= 1'b0;
            ms_prev <= 1'b0;
        end else begin
            ms_meta <= MEAS_STRESS;
            ms_s    <= ms_meta;
            ms_prev <= ms_s;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (ENABLE) state_next = WAIT_INTERVAL;
            end
            WAIT_INTERVAL: begin
                if (!ENABLE) begin
                    state_next = IDLE;
                end else if (icnt == '0) begin
                    state_next = TRIG;
                end
            end
            TRIG: begin
                if (pcnt == TRIG_LAST) state_next = WAIT_START;
            end
            WAIT_START: begin
                if (ms_s) begin
                    state_next = WAIT_DONE;
                end else if (wd_hit) begin
                    state_next = CAPTURE;
                end
            end
            WAIT_DONE: begin
                if (!ms_s && ms_prev) begin
                    state_next = SETTLE;
                end else if (wd_hit) begin
                    state_next = CAPTURE;
                end
            end
            SETTLE: begin
                if (pcnt == SETTLE_LAST) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (!ENABLE || last_meas) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_INTERVAL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered trigger output.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            meas_trig <= 1'b0;
        end else begin
            state     <= state_next;
            meas_trig <= (state_next == TRIG);
        end
    end

    // Interval countdown, loaded from INTERVAL on entry to WAIT_INTERVAL.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            icnt <= '0;
        end else if (state_next == WAIT_INTERVAL &&
                     state != WAIT_INTERVAL) begin
            icnt <= INTERVAL;
        end else if (state == WAIT_INTERVAL) begin
            icnt <= icnt - INTERVAL_W'(1);
        end
    end

    // Phase counter shared by TRIG and SETTLE, cleared on state entry.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pcnt <= '0;
        end else if (entering) begin
            pcnt <= '0;
        end else if (state == TRIG || state == SETTLE) begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Campaign measurement count and sticky overflow.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meas_cnt <= 8'd0;
            overflow <= 1'b0;
        end else begin
            if (state == IDLE && ENABLE) begin
                meas_cnt <= 8'd0;
            end else if (cap && meas_cnt != 8'hFF) begin
                meas_cnt <= meas_cnt + 8'd1;
            end
            if (cap && !push) overflow <= 1'b1;
        end
    end

    // FIFO pointers with an extra wrap bit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // FIFO storage; contents are don't-care while unoccupied.
    always_ff @(posedge CLK) begin
        if (push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_odometer_meas_seq.sv
// Directed self-checking bench for odometer_meas_seq.
// Optional watchdog scenario runs when ODO_SEQ_TIMEOUT_EN is defined.
module tb_odometer_meas_seq;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [15:0] INTERVAL;
    logic [7:0]  NUM_MEAS;
    logic        MEAS_STRESS;
    logic [11:0] BF_COUNT;
    logic        MEAS_TRIG;
    logic        BUSY;
    logic [11:0] RD_DATA;
    logic        RD_VALID;
    logic        RD_READY;
    logic        FIFO_FULL;
    logic        OVERFLOW;
    logic [7:0]  MEAS_CNT;
    logic        TIMEOUT_ERR;

    int errors = 0;
    int checks = 0;
    logic model_en = 1'b1;

    int cyc, trg, first, hi, full_at, ovf_at;
    bit tmo;
    logic [11:0] popped [$];

    odometer_meas_seq #(
        .INTERVAL_W(16), .FIFO_DEPTH(8), .TRIG_CYCLES(4),
        .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(50)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
        .INTERVAL(INTERVAL), .NUM_MEAS(NUM_MEAS),
        .MEAS_STRESS(MEAS_STRESS), .BF_COUNT(BF_COUNT),
        .MEAS_TRIG(MEAS_TRIG), .BUSY(BUSY), .RD_DATA(RD_DATA),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .FIFO_FULL(FIFO_FULL), .OVERFLOW(OVERFLOW),
        .MEAS_CNT(MEAS_CNT), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    // Odometer model: stress rises 3 cycles after trigger, lasts 20.
    initial begin
        MEAS_STRESS = 1'b0;
        forever begin
            @(posedge MEAS_TRIG);
            if (model_en) begin
                repeat (3) @(posedge CLK);
                #1 MEAS_STRESS = 1'b1;
                repeat (20) @(posedge CLK);
                #1 MEAS_STRESS = 1'b0;
            end
        end
    end

    // Run until BUSY drops, then drop ENABLE so no new campaign starts.
    task automatic wait_idle(input int budget, input bit auto_bf);
        logic prev_trig;
        prev_trig = 1'b0;
        cyc = 0; trg = 0; first = -1; hi = 0;
        full_at = -1; ovf_at = -1; tmo = 1'b1;
        popped.delete();
        for (int k = 1; k <= budget; k++) begin
            @(negedge CLK);
            if (MEAS_TRIG) hi++;
            if (MEAS_TRIG && !prev_trig) begin
                trg++;
                if (first < 0) first = k;
                if (auto_bf) BF_COUNT = 12'(trg);
            end
            prev_trig = MEAS_TRIG;
            if (FIFO_FULL && full_at < 0) full_at = int'(MEAS_CNT);
            if (OVERFLOW && ovf_at < 0) ovf_at = int'(MEAS_CNT);
            if (RD_VALID && RD_READY) popped.push_back(RD_DATA);
            if (!BUSY) begin
                cyc = k;
                ENABLE = 1'b0;
                tmo = 1'b0;
                break;
            end
        end
        ENABLE = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; ENABLE = 1'b0; INTERVAL = '0; NUM_MEAS = '0;
        BF_COUNT = '0; RD_READY = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (MEAS_TRIG !== 1'b0) begin errors++;
            $display("FAIL reset_trig: got %b want 0", MEAS_TRIG); end
        checks++; if (BUSY !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++; if (RD_VALID !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", RD_VALID); end
        checks++; if (RD_DATA !== 12'h000) begin errors++;
            $display("FAIL reset_data: got %h want 000", RD_DATA); end
        checks++; if (FIFO_FULL !== 1'b0) begin errors++;
            $display("FAIL reset_full: got %b want 0", FIFO_FULL); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++;
            $display("FAIL reset_ovf: got %b want 0", OVERFLOW); end
        checks++; if (MEAS_CNT !== 8'd0) begin errors++;
            $display("FAIL reset_cnt: got %0d want 0", MEAS_CNT); end
        checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++;
            $display("FAIL reset_to: got %b want 0", TIMEOUT_ERR); end
        RESET = 1'b0;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++;
            $display("FAIL reset_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_single();
        NUM_MEAS = 8'd1; INTERVAL = 16'd10; BF_COUNT = 12'h5A3;
        RD_READY = 1'b0; ENABLE = 1'b1;
        wait_idle(400, 1'b0);
        checks++; if (tmo !== 1'b0) begin errors++;
            $display("FAIL single_timeout: got busy want idle"); end
        checks++; if (first != 12) begin errors++;
            $display("FAIL single_trig_start: got %0d want 12", first); end
        checks++; if (hi != 4) begin errors++;
            $display("FAIL single_trig_len: got %0d want 4", hi); end
        checks++; if (trg != 1) begin errors++;
            $display("FAIL single_pulses: got %0d want 1", trg); end
        checks++; if (cyc != 41) begin errors++;
            $display("FAIL single_cycles: got %0d want 41", cyc); end
        checks++; if (RD_VALID !== 1'b1) begin errors++;
            $display("FAIL single_valid: got %b want 1", RD_VALID); end
        checks++; if (RD_DATA !== 12'h5A3) begin errors++;
            $display("FAIL single_data: got %h want 5a3", RD_DATA); end
        checks++; if (MEAS_CNT !== 8'd1) begin errors++;
            $display("FAIL single_cnt: got %0d want 1", MEAS_CNT); end
        RD_READY = 1'b1;
        @(negedge CLK);
        checks++; if (RD_VALID !== 1'b0) begin errors++;
            $display("FAIL single_pop: got %b want 0", RD_VALID); end
        checks++; if (BUSY !== 1'b0) begin errors++;
            $display("FAIL single_stay_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_campaign();
        NUM_MEAS = 8'd3; INTERVAL = 16'd2; BF_COUNT = 12'h000;
        RD_READY = 1'b1; ENABLE = 1'b1;
        wait_idle(1000, 1'b1);
        checks++; if (tmo !== 1'b0) begin errors++;
            $display("FAIL camp_timeout: got busy want idle"); end
        checks++; if (trg != 3) begin errors++;
            $display("FAIL camp_pulses: got %0d want 3", trg); end
        checks++; if (popped.size() != 3) begin errors++;
            $display("FAIL camp_reads: got %0d want 3", popped.size()); end
        for (int i = 0; i < popped.size() && i < 3; i++) begin
            checks++; if (popped[i] !== 12'(i + 1)) begin errors++;
                $display("FAIL camp_data%0d: got %h want %h",
                         i, popped[i], 12'(i + 1)); end
        end
        checks++; if (MEAS_CNT !== 8'd3) begin errors++;
            $display("FAIL camp_cnt: got %0d want 3", MEAS_CNT); end
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0 || RD_VALID !== 1'b0) begin errors++;
            $display("FAIL camp_end: got busy=%b valid=%b want 0 0",
                     BUSY, RD_VALID); end
    endtask

    task automatic test_overflow();
        NUM_MEAS = 8'd10; INTERVAL = 16'd0; BF_COUNT = 12'h000;
        RD_READY = 1'b0; ENABLE = 1'b1;
        wait_idle(3000, 1'b1);
        checks++; if (tmo !== 1'b0) begin errors++;
            $display("FAIL ovf_timeout: got busy want idle"); end
        checks++; if (full_at != 8) begin errors++;
            $display("FAIL ovf_full_at: got %0d want 8", full_at); end
        checks++; if (ovf_at != 9) begin errors++;
            $display("FAIL ovf_set_at: got %0d want 9", ovf_at); end
        checks++; if (MEAS_CNT !== 8'd10) begin errors++;
            $display("FAIL ovf_cnt: got %0d want 10", MEAS_CNT); end
        checks++; if (FIFO_FULL !== 1'b1 || OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flags: got full=%b ovf=%b want 1 1",
                     FIFO_FULL, OVERFLOW); end
        RD_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (RD_VALID !== 1'b1 || RD_DATA !== 12'(i + 1)) begin
                errors++;
                $display("FAIL ovf_drain%0d: got v=%b d=%h want 1 %h",
                         i, RD_VALID, RD_DATA, 12'(i + 1)); end
            @(negedge CLK);
        end
        checks++; if (RD_VALID !== 1'b0 || FIFO_FULL !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: got v=%b full=%b want 0 0",
                     RD_VALID, FIFO_FULL); end
        RD_READY = 1'b0;
    endtask

    task automatic test_abort_interval();
        int trig_seen;
        trig_seen = 0;
        NUM_MEAS = 8'd0; INTERVAL = 16'd20; ENABLE = 1'b1;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b1 || MEAS_CNT !== 8'd0) begin errors++;
            $display("FAIL abi_start: got busy=%b cnt=%0d want 1 0",
                     BUSY, MEAS_CNT); end
        repeat (5) begin
            @(negedge CLK);
            if (MEAS_TRIG) trig_seen++;
        end
        ENABLE = 1'b0;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++;
            $display("FAIL abi_idle: got %b want 0", BUSY); end
        repeat (30) begin
            @(negedge CLK);
            if (MEAS_TRIG) trig_seen++;
        end
        checks++; if (trig_seen != 0) begin errors++;
            $display("FAIL abi_notrig: got %0d want 0", trig_seen); end
    endtask

    task automatic test_abort_done();
        bit seen;
        int trig_seen;
        logic prev_trig;
        seen = 1'b0; trig_seen = 0; prev_trig = 1'b0;
        NUM_MEAS = 8'd0; INTERVAL = 16'd1; BF_COUNT = 12'h077;
        RD_READY = 1'b0; ENABLE = 1'b1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge CLK);
            if (MEAS_TRIG && !prev_trig) trig_seen++;
            prev_trig = MEAS_TRIG;
            if (MEAS_STRESS) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++;
            $display("FAIL abd_stress: got no stress want stress"); end
        repeat (6) @(negedge CLK);
        ENABLE = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge CLK);
            if (MEAS_TRIG && !prev_trig) trig_seen++;
            prev_trig = MEAS_TRIG;
            if (!BUSY) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++;
            $display("FAIL abd_timeout: got busy want idle"); end
        checks++; if (trig_seen != 1) begin errors++;
            $display("FAIL abd_pulses: got %0d want 1", trig_seen); end
        checks++; if (MEAS_CNT !== 8'd1) begin errors++;
            $display("FAIL abd_cnt: got %0d want 1", MEAS_CNT); end
        checks++; if (RD_VALID !== 1'b1 || RD_DATA !== 12'h077) begin
            errors++;
            $display("FAIL abd_data: got v=%b d=%h want 1 077",
                     RD_VALID, RD_DATA); end
        repeat (3) @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++;
            $display("FAIL abd_stay_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        NUM_MEAS = 8'd0; INTERVAL = 16'd0; ENABLE = 1'b1;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge CLK);
            if (MEAS_TRIG) seen = 1'b1;
        end
        checks++; if (MEAS_TRIG !== 1'b1) begin errors++;
            $display("FAIL rst_pre_trig: got %b want 1", MEAS_TRIG); end
        #1 RESET = 1'b1;
        #1;
        checks++; if (MEAS_TRIG !== 1'b0 || BUSY !== 1'b0) begin errors++;
            $display("FAIL rst_trig: got trig=%b busy=%b want 0 0",
                     MEAS_TRIG, BUSY); end
        checks++; if (RD_VALID !== 1'b0 || RD_DATA !== 12'h000) begin
            errors++;
            $display("FAIL rst_fifo: got v=%b d=%h want 0 000",
                     RD_VALID, RD_DATA); end
        checks++; if (OVERFLOW !== 1'b0 || FIFO_FULL !== 1'b0 ||
                      MEAS_CNT !== 8'd0 || TIMEOUT_ERR !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags: got ovf=%b full=%b cnt=%0d to=%b want 0",
                     OVERFLOW, FIFO_FULL, MEAS_CNT, TIMEOUT_ERR); end
        ENABLE = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (40) @(negedge CLK);
        checks++; if (BUSY !== 1'b0 || RD_VALID !== 1'b0) begin errors++;
            $display("FAIL rst_after: got busy=%b v=%b want 0 0",
                     BUSY, RD_VALID); end
    endtask

`ifdef ODO_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        model_en = 1'b0;
        NUM_MEAS = 8'd1; INTERVAL = 16'd0; BF_COUNT = 12'h123;
        RD_READY = 1'b0; ENABLE = 1'b1;
        @(negedge CLK);
        checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++;
            $display("FAIL to_pre: got %b want 0", TIMEOUT_ERR); end
        wait_idle(500, 1'b0);
        checks++; if (tmo !== 1'b0) begin errors++;
            $display("FAIL to_hang: got busy want idle"); end
        checks++; if (cyc != 56) begin errors++;
            $display("FAIL to_cycles: got %0d want 56", cyc); end
        checks++; if (TIMEOUT_ERR !== 1'b1) begin errors++;
            $display("FAIL to_flag: got %b want 1", TIMEOUT_ERR); end
        checks++; if (RD_VALID !== 1'b1 || RD_DATA !== 12'hFFF) begin
            errors++;
            $display("FAIL to_marker: got v=%b d=%h want 1 fff",
                     RD_VALID, RD_DATA); end
        checks++; if (MEAS_CNT !== 8'd1) begin errors++;
            $display("FAIL to_cnt: got %0d want 1", MEAS_CNT); end
        model_en = 1'b1;
    endtask
`else
    task automatic test_no_timeout();
        checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++;
            $display("FAIL no_to_flag: got %b want 0", TIMEOUT_ERR); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_campaign();
        test_overflow();
        test_abort_interval();
        test_abort_done();
        test_reset_mid();
`ifdef ODO_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/odometer_meas_seq.md
Name: odometer_meas_seq

Overview:
- Clocked measurement sequencer for the odometer.
- Sits upstream of the odometer top-level: periodically pulses MEAS_TRIG to start a measurement.
- Also consumes its outputs: waits for MEAS_STRESS to fall, then captures the 12-bit BF_COUNT result into a small result FIFO.
- Results are drained through a valid/ready read port by the chip's readout logic.

Parameters:
- INTERVAL_W, 16, width of the programmable idle interval between measurements (CLK cycles).
- FIFO_DEPTH, 8, result FIFO entries; power of two, at least 2.
- TRIG_CYCLES, 4, MEAS_TRIG high time in CLK cycles, at least 1.
- SETTLE_CYCLES, 2, CLK cycles waited after synchronized MEAS_STRESS falls before BF_COUNT is sampled.
- TIMEOUT_CYCLES, 65535, watchdog limit per wait state; used only with ODO_SEQ_TIMEOUT_EN.

Ports:
- CLK  in  1  sequencer clock.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  level; 1 = run measurement campaign.
- INTERVAL  in  INTERVAL_W  cycles spent in WAIT_INTERVAL before each trigger; sampled on entry to WAIT_INTERVAL.
- NUM_MEAS  in  8  measurements per campaign; 0 = continuous.
- MEAS_STRESS  in  1  from odometer top-level; asynchronous to CLK.
- BF_COUNT  in  12  latched result from odometer top-level; quasi-static after MEAS_STRESS falls.
- MEAS_TRIG  out  1  registered trigger pulse to odometer top-level.
- BUSY  out  1  1 whenever state is not IDLE.
- RD_DATA  out  12  FIFO head.
- RD_VALID  out  1  FIFO not empty.
- RD_READY  in  1  pop when RD_VALID && RD_READY.
- FIFO_FULL  out  1  FIFO holds FIFO_DEPTH entries.
- OVERFLOW  out  1  sticky; set when a capture finds the FIFO full.
- MEAS_CNT  out  8  measurements completed in the current campaign.
- TIMEOUT_ERR  out  1  sticky watchdog flag; tied 0 without the macro.

Behaviour:
- Reset values: all outputs 0, RD_DATA 0, FIFO empty, state IDLE, synchronizer flops 0.
- MEAS_STRESS passes a 2-flop synchronizer (MS_S). All edge detection uses MS_S and its previous value.
- IDLE: when ENABLE=1, clear MEAS_CNT and go to WAIT_INTERVAL.
- WAIT_INTERVAL: load the counter with INTERVAL on entry and decrement. At 0, go to TRIG. INTERVAL=0 means one cycle in this state.
- TRIG: MEAS_TRIG=1 for exactly TRIG_CYCLES cycles, then go to WAIT_START.
- WAIT_START: wait for MS_S=1, then go to WAIT_DONE. If MS_S is already 1 (trigger seen before the edge), take the same transition.
- WAIT_DONE: on a falling edge of MS_S, go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to CAPTURE.
- CAPTURE (1 cycle):
  - If the FIFO is not full, push BF_COUNT. If it is full, drop the sample and set OVERFLOW.
  - MEAS_CNT increments in either case, saturating at 255.
  - If NUM_MEAS!=0 and MEAS_CNT+1==NUM_MEAS, go to IDLE; otherwise go to WAIT_INTERVAL.
- ENABLE=0 in WAIT_INTERVAL: return to IDLE next cycle.
- ENABLE=0 in TRIG, WAIT_START, WAIT_DONE, SETTLE or CAPTURE: the in-flight measurement completes and is captured, then the block goes to IDLE.
- ENABLE=1 while IDLE after a finished campaign starts a new campaign. OVERFLOW and TIMEOUT_ERR are not cleared by this; only RESET clears them.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits with wrap-around.
  - RD_DATA is valid combinationally from head storage whenever RD_VALID=1.
  - Push and pop in the same cycle: both occur and occupancy is unchanged.
  - When full, a same-cycle pop still makes room for the capture.
- RESET mid-operation: immediate return to reset values; FIFO contents are discarded.

Optional Feature:
- Macro: ODO_SEQ_TIMEOUT_EN.
- With the macro:
  - A watchdog counter runs in WAIT_START and WAIT_DONE and restarts on entry to each.
  - When it reaches TIMEOUT_CYCLES: set TIMEOUT_ERR, push 12'hFFF as the error marker (same full/overflow rules), count the measurement, and take the normal CAPTURE exit.
- Without the macro: no watchdog logic; TIMEOUT_ERR is constant 0, and the block waits indefinitely.

Test Plan:
- Single measurement:
  - Stimulus: NUM_MEAS=1, INTERVAL=10, ENABLE=1. MEAS_STRESS model rises 3 cycles after MEAS_TRIG and falls after 20 cycles; BF_COUNT=12'h5A3.
  - Required: MEAS_TRIG high exactly 4 cycles, starting 12 cycles after ENABLE; one FIFO entry 12'h5A3; MEAS_CNT=1; BUSY falls.
- Campaign of 3:
  - Stimulus: NUM_MEAS=3, BF_COUNT values 1, 2, 3, RD_READY=1.
  - Required: RD_DATA sequence 1, 2, 3; three MEAS_TRIG pulses; MEAS_CNT=3; then IDLE.
- Overflow:
  - Stimulus: NUM_MEAS=10, RD_READY=0.
  - Required: FIFO_FULL after 8 captures; OVERFLOW=1 on the 9th; entries 0..7 hold the first 8 values; MEAS_CNT=10.
- Abort:
  - Stimulus: deassert ENABLE during WAIT_INTERVAL.
  - Required: IDLE next cycle, no MEAS_TRIG.
  - Stimulus: deassert ENABLE during WAIT_DONE.
  - Required: that measurement is captured, then IDLE.
- Reset mid-campaign:
  - Stimulus: assert RESET during TRIG.
  - Required: MEAS_TRIG=0 immediately; FIFO empty; all flags 0.
- Timeout (with ODO_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50):
  - Stimulus: MEAS_STRESS held 0.
  - Required: after 50 cycles in WAIT_START, TIMEOUT_ERR=1 and 12'hFFF is pushed.
